// File: rtl/sdram_arbiter.sv
// sdram_arbiter: shares the SDRAM controller port between the Z80 CPU
// and the HPS ioctl loader, one access at a time, with a timeout abort.
module sdram_arbiter #(
  parameter int AW       = 25,
  parameter int DW       = 8,
  parameter int DL_BURST = 16,
  parameter int TIMEOUT  = 64
) (
  input  logic          clk_sys,
  input  logic          reset,
  input  logic          cpu_req,
  input  logic          cpu_we,
  input  logic [AW-1:0] cpu_addr,
  input  logic [DW-1:0] cpu_din,
  output logic [DW-1:0] cpu_dout,
  output logic          cpu_ack,
  input  logic          ioctl_download,
  input  logic          ioctl_wr,
  input  logic [AW-1:0] ioctl_addr,
  input  logic [DW-1:0] ioctl_dout,
  output logic          ioctl_wait,
  output logic          copy_in_progress,
  output logic          mem_req,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_din,
  input  logic [DW-1:0] mem_dout,
  input  logic          mem_ready,
  output logic          timeout_err
);

  localparam int BW = $clog2(DL_BURST + 1);
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [BW-1:0] BMAX  = BW'(DL_BURST);
  localparam logic [TW-1:0] TLAST = TW'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE,
    DL_ACC,
    CPU_ACC
  } state_t;

  state_t        state;
  state_t        state_nx;
  logic          lat_pend;
  logic [AW-1:0] lat_addr;
  logic [DW-1:0] lat_data;
  logic [BW-1:0] burst;
  logic [TW-1:0] tcnt;
  logic          dl_pend;
  logic          go_dl;
  logic          go_cpu;
  logic          fin;
  logic          expire;

  // A strobe arriving in IDLE competes in the same cycle it is latched.
  assign dl_pend = lat_pend | ioctl_wr;

  always_comb begin
    state_nx = state;
    go_dl    = 1'b0;
    go_cpu   = 1'b0;
    fin      = 1'b0;
    expire   = 1'b0;
    unique case (state)
      IDLE: begin
        if (dl_pend && (!cpu_req || burst < BMAX)) begin
          go_dl    = 1'b1;
          state_nx = DL_ACC;
        end else if (cpu_req) begin
          go_cpu   = 1'b1;
          state_nx = CPU_ACC;
        end
      end
      DL_ACC, CPU_ACC: begin
        expire = !mem_ready && (tcnt == TLAST);
        fin    = mem_ready || expire;
        if (fin) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk_sys) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      lat_pend    <= 1'b0;
      lat_addr    <= '0;
      lat_data    <= '0;
      burst       <= '0;
      tcnt        <= '0;
      mem_req     <= 1'b0;
      mem_we      <= 1'b0;
      mem_addr    <= '0;
      mem_din     <= '0;
      cpu_ack     <= 1'b0;
      cpu_dout    <= '0;
      timeout_err <= 1'b0;
    end else begin
      mem_req <= go_dl | go_cpu;
      cpu_ack <= 1'b0;
      if (ioctl_wr && !lat_pend) begin
        lat_pend <= 1'b1;
        lat_addr <= ioctl_addr;
        lat_data <= ioctl_dout;
      end
      if (go_dl) begin
        mem_we   <= 1'b1;
        mem_addr <= lat_pend ? lat_addr : ioctl_addr;
        mem_din  <= lat_pend ? lat_data : ioctl_dout;
        tcnt     <= '0;
      end
      if (go_cpu) begin
        mem_we   <= cpu_we;
        mem_addr <= cpu_addr;
        mem_din  <= cpu_din;
        tcnt     <= '0;
      end
      if (state != IDLE && !fin) tcnt <= tcnt + TW'(1);
      if (fin) begin
        mem_we <= 1'b0;
        if (expire) timeout_err <= 1'b1;
      end
      if (fin && state == DL_ACC) begin
        lat_pend <= 1'b0;
        if (!cpu_req)            burst <= '0;
        else if (burst != BMAX)  burst <= burst + BW'(1);
      end
      if (fin && state == CPU_ACC) begin
        cpu_ack <= 1'b1;
        burst   <= '0;
        if (expire)      cpu_dout <= {DW{1'b1}};
        else if (mem_we) cpu_dout <= '0;
        else             cpu_dout <= mem_dout;
      end
    end
  end

  assign ioctl_wait       = lat_pend;
  assign copy_in_progress = ioctl_download | lat_pend | (state == DL_ACC);

endmodule

// File: tb/tb_sdram_arbiter.sv
// tb_sdram_arbiter: scoreboard bench; a monitor checks every mem_req
// and cpu_ack against queues filled by the directed stimulus.
module tb_sdram_arbiter;

  logic        clk_sys;
  logic        reset;
  logic        cpu_req;
  logic        cpu_we;
  logic [24:0] cpu_addr;
  logic [7:0]  cpu_din;
  logic [7:0]  cpu_dout;
  logic        cpu_ack;
  logic        ioctl_download;
  logic        ioctl_wr;
  logic [24:0] ioctl_addr;
  logic [7:0]  ioctl_dout;
  logic        ioctl_wait;
  logic        copy_in_progress;
  logic        mem_req;
  logic        mem_we;
  logic [24:0] mem_addr;
  logic [7:0]  mem_din;
  logic [7:0]  mem_dout;
  logic        mem_ready;
  logic        timeout_err;

  sdram_arbiter #(
    .AW(25), .DW(8), .DL_BURST(16), .TIMEOUT(64)
  ) dut (
    .clk_sys(clk_sys),
    .reset(reset),
    .cpu_req(cpu_req),
    .cpu_we(cpu_we),
    .cpu_addr(cpu_addr),
    .cpu_din(cpu_din),
    .cpu_dout(cpu_dout),
    .cpu_ack(cpu_ack),
    .ioctl_download(ioctl_download),
    .ioctl_wr(ioctl_wr),
    .ioctl_addr(ioctl_addr),
    .ioctl_dout(ioctl_dout),
    .ioctl_wait(ioctl_wait),
    .copy_in_progress(copy_in_progress),
    .mem_req(mem_req),
    .mem_we(mem_we),
    .mem_addr(mem_addr),
    .mem_din(mem_din),
    .mem_dout(mem_dout),
    .mem_ready(mem_ready),
    .timeout_err(timeout_err)
  );

  typedef struct packed {
    logic        we;
    logic [24:0] addr;
    logic [7:0]  din;
  } mem_t;

  mem_t       exp_mem[$];
  logic [7:0] exp_ack[$];
  mem_t       e;
  logic [7:0] ea;

  int   errors = 0;
  int   checks = 0;
  int   ack_seen = 0;
  int   req_seen = 0;
  bit   prev_req = 0;
  int   mem_lat = 1;
  int   resp_cnt = 0;
  bit   resp_en = 1;
  logic [7:0] resp_data = 8'h00;

  initial begin
    clk_sys = 0;
    forever #5 clk_sys = ~clk_sys;
  end

  // SDRAM controller model: mem_ready mem_lat cycles after mem_req
  initial begin
    mem_ready = 0;
    mem_dout  = 0;
    forever begin
      @(posedge clk_sys);
      #1;
      mem_ready = 0;
      if (resp_cnt > 0) begin
        resp_cnt--;
        if (resp_cnt == 0) begin
          mem_ready = 1;
          mem_dout  = resp_data;
        end
      end
      if (mem_req && resp_en) resp_cnt = mem_lat;
    end
  end

  always @(negedge clk_sys) begin
    if (reset) begin
      prev_req = 0;
    end else begin
      if (mem_req) begin
        req_seen++;
        checks++;
        if (prev_req) begin
          errors++;
          $display("FAIL back_to_back_req: mem_req high two cycles running");
        end
        checks++;
        if (exp_mem.size() == 0) begin
          errors++;
          $display("FAIL unexpected_mem_req: we=%0d addr=%h din=%h",
                   mem_we, mem_addr, mem_din);
        end else begin
          e = exp_mem.pop_front();
          if (mem_we !== e.we || mem_addr !== e.addr || mem_din !== e.din) begin
            errors++;
            $display("FAIL mem_access: got we=%0d addr=%h din=%h want we=%0d addr=%h din=%h",
                     mem_we, mem_addr, mem_din, e.we, e.addr, e.din);
          end
        end
      end
      if (cpu_ack) begin
        ack_seen++;
        checks++;
        if (exp_ack.size() == 0) begin
          errors++;
          $display("FAIL unexpected_cpu_ack: dout=%h", cpu_dout);
        end else begin
          ea = exp_ack.pop_front();
          if (cpu_dout !== ea) begin
            errors++;
            $display("FAIL cpu_dout: got %h want %h", cpu_dout, ea);
          end
        end
      end
      prev_req = mem_req;
    end
  end

  task automatic chk(input string name, input logic [31:0] got,
                     input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %0h want %0h", name, got, want);
    end
  endtask

  task automatic tick();
    @(posedge clk_sys);
    #1;
  endtask

  // Holds cpu_req until cpu_ack; returns cycles from first mem_req to ack
  task automatic cpu_access(input logic we, input logic [24:0] a,
                            input logic [7:0] d, output int req2ack);
    int  c;
    int  rq;
    bit  done;
    cpu_we   = we;
    cpu_addr = a;
    cpu_din  = d;
    cpu_req  = 1;
    c = 0;
    rq = -1;
    done = 0;
    req2ack = -1;
    while (!done && c < 400) begin
      tick();
      c++;
      if (mem_req && rq < 0) rq = c;
      if (cpu_ack) begin
        req2ack = c - rq;
        done = 1;
      end
    end
    cpu_req = 0;
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL cpu_ack_wait: no ack within 400 cycles");
    end
  endtask

  task automatic dl_write(input logic [24:0] a, input logic [7:0] d);
    int n;
    n = 0;
    while (ioctl_wait && n < 100) begin
      tick();
      n++;
    end
    if (ioctl_wait) begin
      checks++;
      errors++;
      $display("FAIL ioctl_wait_stuck: still high after 100 cycles");
    end
    ioctl_wr   = 1;
    ioctl_addr = a;
    ioctl_dout = d;
    tick();
    ioctl_wr = 0;
  endtask

  initial begin
    int  lat;
    int  n;
    bit  cip_low;
    int  acks0;
    int  reqs0;
    reset = 1;
    cpu_req = 0;
    cpu_we = 0;
    cpu_addr = 0;
    cpu_din = 0;
    ioctl_download = 0;
    ioctl_wr = 0;
    ioctl_addr = 0;
    ioctl_dout = 0;
    repeat (3) @(posedge clk_sys);
    #1;
    chk("rst_mem_req", mem_req, 0);
    chk("rst_mem_we", mem_we, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_mem_din", mem_din, 0);
    chk("rst_cpu_ack", cpu_ack, 0);
    chk("rst_cpu_dout", cpu_dout, 0);
    chk("rst_ioctl_wait", ioctl_wait, 0);
    chk("rst_copy", copy_in_progress, 0);
    chk("rst_timeout_err", timeout_err, 0);
    reset = 0;
    tick();

    // single CPU read, latency 5
    mem_lat = 5;
    resp_data = 8'hA5;
    exp_mem.push_back('{1'b0, 25'h8010, 8'h3C});
    exp_ack.push_back(8'hA5);
    cpu_access(1'b0, 25'h8010, 8'h3C, lat);
    chk("read_latency", lat, 6);
    tick();
    chk("idle_mem_we", mem_we, 0);
    chk("idle_mem_addr_hold", mem_addr, 32'h8010);

    // CPU write returns zero data
    mem_lat = 1;
    resp_data = 8'hEE;
    exp_mem.push_back('{1'b1, 25'h20, 8'h77});
    exp_ack.push_back(8'h00);
    cpu_access(1'b1, 25'h20, 8'h77, lat);
    chk("write_latency", lat, 2);
    tick();

    // loader stream of 40 writes, latency 3
    mem_lat = 3;
    ioctl_download = 1;
    cip_low = 0;
    tick();
    for (int i = 0; i < 40; i++) begin
      exp_mem.push_back('{1'b1, 25'(i), 8'(i)});
      ioctl_wr   = 1;
      ioctl_addr = 25'(i);
      ioctl_dout = 8'(i);
      tick();
      ioctl_wr = 0;
      n = 0;
      while (ioctl_wait && n < 50) begin
        if (!copy_in_progress) cip_low = 1;
        n++;
        tick();
      end
      chk($sformatf("dl_wait_len[%0d]", i), n, 4);
    end
    chk("dl_copy_high", cip_low, 0);
    ioctl_download = 0;
    tick();
    chk("dl_copy_low", copy_in_progress, 0);

    // simultaneous request: loader first, CPU second
    mem_lat = 3;
    resp_data = 8'hC3;
    exp_mem.push_back('{1'b1, 25'h200, 8'h99});
    exp_mem.push_back('{1'b0, 25'h300, 8'h00});
    exp_ack.push_back(8'hC3);
    fork
      begin
        ioctl_wr   = 1;
        ioctl_addr = 25'h200;
        ioctl_dout = 8'h99;
        tick();
        ioctl_wr = 0;
      end
      cpu_access(1'b0, 25'h300, 8'h00, lat);
    join
    chk("tie_latency", lat, 9);
    tick();

    // starvation bound: 16 loader grants then the CPU
    mem_lat = 2;
    resp_data = 8'h5A;
    for (int k = 0; k < 16; k++)
      exp_mem.push_back('{1'b1, 25'(32'h100 + k), 8'(32'h40 + k)});
    exp_mem.push_back('{1'b0, 25'h1234, 8'h00});
    exp_mem.push_back('{1'b1, 25'h110, 8'h50});
    exp_ack.push_back(8'h5A);
    ioctl_download = 1;
    fork
      begin
        for (int k = 0; k < 17; k++)
          dl_write(25'(32'h100 + k), 8'(32'h40 + k));
      end
      cpu_access(1'b0, 25'h1234, 8'h00, lat);
    join
    n = 0;
    while (ioctl_wait && n < 50) begin
      tick();
      n++;
    end
    chk("starve_latch_drained", ioctl_wait, 0);
    ioctl_download = 0;
    repeat (3) tick();

    // timeout abort
    resp_en = 0;
    exp_mem.push_back('{1'b0, 25'h777, 8'h00});
    exp_ack.push_back(8'hFF);
    cpu_access(1'b0, 25'h777, 8'h00, lat);
    chk("timeout_latency", lat, 64);
    chk("timeout_err_set", timeout_err, 1);
    repeat (5) tick();
    chk("timeout_err_sticky", timeout_err, 1);
    resp_en = 1;

    // reset two cycles after mem_req, with a loader write latched
    mem_lat = 10;
    resp_data = 8'h11;
    exp_mem.push_back('{1'b0, 25'h555, 8'hAB});
    cpu_we   = 0;
    cpu_addr = 25'h555;
    cpu_din  = 8'hAB;
    cpu_req  = 1;
    n = 0;
    while (!mem_req && n < 20) begin
      tick();
      n++;
    end
    chk("rst_acc_granted", mem_req, 1);
    tick();
    ioctl_wr   = 1;
    ioctl_addr = 25'h3FF;
    ioctl_dout = 8'h5E;
    tick();
    ioctl_wr = 0;
    chk("rst_acc_wait_pre", ioctl_wait, 1);
    reset   = 1;
    cpu_req = 0;
    acks0 = ack_seen;
    tick();
    chk("rst_acc_mem_req", mem_req, 0);
    chk("rst_acc_mem_we", mem_we, 0);
    chk("rst_acc_mem_addr", mem_addr, 0);
    chk("rst_acc_mem_din", mem_din, 0);
    chk("rst_acc_cpu_ack", cpu_ack, 0);
    chk("rst_acc_cpu_dout", cpu_dout, 0);
    chk("rst_acc_ioctl_wait", ioctl_wait, 0);
    chk("rst_acc_copy", copy_in_progress, 0);
    chk("rst_acc_timeout_err", timeout_err, 0);
    reset = 0;
    reqs0 = req_seen;
    repeat (15) tick();
    chk("rst_acc_no_ack", ack_seen - acks0, 0);
    chk("rst_acc_no_req", req_seen - reqs0, 0);

    chk("mem_queue_empty", exp_mem.size(), 0);
    chk("ack_queue_empty", exp_ack.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
